// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests a word at pc_cur, holds it for decode, then loads the next PC.
// Optional fetch timeout guarded by macro FETCH_TIMEOUT_EN (fetch_err tied low when undefined).
module fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE    = 4'hF,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_next,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc_cur,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = '0;
    err_d    = err_q;
`endif
    unique case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        // The cycle that reaches the limit still honours a late ack above.
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (!stall && instr_ready) begin
          // Instructions are halfword aligned, so the LSB is forced low.
          pc_d    = pc_next & 16'hFFFE;
          valid_d = 1'b0;
          if (instr_q[15:12] == HALT_OPCODE) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Gating with rst_n keeps the request low while reset holds the state at FETCH.
  assign imem_req    = rst_n && (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc_cur      = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for the main flow plus reset and timeout sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_next;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc_cur;
  logic        halted;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_next    (pc_next),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc_cur     (pc_cur),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc_next;
    logic        stall;
    logic        ack;
    logic [15:0] rdata;
    logic        ready;
    logic        exp_req;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
    logic        exp_valid;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    pc_next     = 16'h0000;
    stall       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 16'h0000;
    instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #7;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // pc_next stall ack rdata ready | req pc instr valid halted
    vecs[0]  = '{16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0};
    vecs[3]  = '{16'h0042, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0};
    vecs[4]  = '{16'h0042, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0};
    vecs[5]  = '{16'h0042, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0};
    vecs[6]  = '{16'h0042, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0042, 16'h1234, 1'b0, 1'b0};
    vecs[7]  = '{16'h0000, 1'b0, 1'b1, 16'hA000, 1'b0, 1'b0, 16'h0042, 16'hA000, 1'b1, 1'b0};
    vecs[8]  = '{16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0042, 16'hA000, 1'b1, 1'b0};
    vecs[9]  = '{16'h0043, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0042, 16'hA000, 1'b0, 1'b0};
    vecs[10] = '{16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0042, 16'hA000, 1'b0, 1'b0};
    vecs[11] = '{16'h0000, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 16'h0042, 16'hF000, 1'b1, 1'b0};
    vecs[12] = '{16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFE, 16'hF000, 1'b0, 1'b1};
    vecs[13] = '{16'h0010, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 16'hFFFE, 16'hF000, 1'b0, 1'b1};
    vecs[14] = '{16'h0010, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 16'hFFFE, 16'hF000, 1'b0, 1'b1};

    idle_inputs();
    rst_n = 1'b0;
    #23;
    chk("reset_req", {15'd0, imem_req}, 16'd0);
    chk("reset_pc", pc_cur, 16'h0000);
    chk("reset_instr", instr, 16'h0000);
    chk("reset_valid", {15'd0, instr_valid}, 16'd0);
    chk("reset_halted", {15'd0, halted}, 16'd0);
    chk("reset_err", {15'd0, fetch_err}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_req", {15'd0, imem_req}, 16'd1);
    $display("reset released: req=%b addr=%h", imem_req, imem_addr);

    for (int i = 0; i < 15; i++) begin
      pc_next     = vecs[i].pc_next;
      stall       = vecs[i].stall;
      imem_ack    = vecs[i].ack;
      imem_rdata  = vecs[i].rdata;
      instr_ready = vecs[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", i), {15'd0, imem_req}, {15'd0, vecs[i].exp_req});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_pc);
      chk($sformatf("v%0d_pc", i), pc_cur, vecs[i].exp_pc);
      chk($sformatf("v%0d_instr", i), instr, vecs[i].exp_instr);
      chk($sformatf("v%0d_valid", i), {15'd0, instr_valid}, {15'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_halted", i), {15'd0, halted}, {15'd0, vecs[i].exp_halted});
      chk($sformatf("v%0d_err", i), {15'd0, fetch_err}, 16'd0);
      $display("vec %0d: req=%b pc=%h instr=%h valid=%b halted=%b", i, imem_req, pc_cur, instr, instr_valid, halted);
    end

    // Asynchronous reset out of HALT, with an ack arriving during reset.
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 16'h7777;
    #1;
    chk("halt_rst_halted", {15'd0, halted}, 16'd0);
    chk("halt_rst_pc", pc_cur, 16'h0000);
    chk("halt_rst_instr", instr, 16'h0000);
    chk("halt_rst_req", {15'd0, imem_req}, 16'd0);
    @(posedge clk);
    #1;
    chk("rst_ack_ignored_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_ack_ignored_instr", instr, 16'h0000);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    chk("halt_exit_req", {15'd0, imem_req}, 16'd1);
    $display("reset from HALT: halted=%b req=%b pc=%h", halted, imem_req, pc_cur);

    // Asynchronous reset while holding a valid instruction.
    imem_ack   = 1'b1;
    imem_rdata = 16'h5678;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    chk("hold_valid", {15'd0, instr_valid}, 16'd1);
    chk("hold_instr", instr, 16'h5678);
    #3;
    rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("hold_rst_pc", pc_cur, 16'h0000);
    chk("hold_rst_instr", instr, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_rst_resume_req", {15'd0, imem_req}, 16'd1);
    chk("hold_rst_resume_valid", {15'd0, instr_valid}, 16'd0);
    $display("reset from HOLD: valid=%b req=%b pc=%h", instr_valid, imem_req, pc_cur);

`ifdef FETCH_TIMEOUT_EN
    do_reset();
    repeat (14) @(posedge clk);
    #1;
    chk("to14_err", {15'd0, fetch_err}, 16'd0);
    chk("to14_halted", {15'd0, halted}, 16'd0);
    chk("to14_req", {15'd0, imem_req}, 16'd1);
    @(posedge clk);
    #1;
    chk("to15_err", {15'd0, fetch_err}, 16'd1);
    chk("to15_halted", {15'd0, halted}, 16'd1);
    chk("to15_req", {15'd0, imem_req}, 16'd0);
    $display("timeout: err=%b halted=%b", fetch_err, halted);

    do_reset();
    repeat (14) @(posedge clk);
    #1;
    imem_ack   = 1'b1;
    imem_rdata = 16'h9ABC;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    chk("late_ack_err", {15'd0, fetch_err}, 16'd0);
    chk("late_ack_halted", {15'd0, halted}, 16'd0);
    chk("late_ack_valid", {15'd0, instr_valid}, 16'd1);
    chk("late_ack_instr", instr, 16'h9ABC);
    $display("ack on limit cycle: err=%b valid=%b instr=%h", fetch_err, instr_valid, instr);
`else
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    chk("wait_req", {15'd0, imem_req}, 16'd1);
    chk("wait_halted", {15'd0, halted}, 16'd0);
    chk("wait_err", {15'd0, fetch_err}, 16'd0);
    chk("wait_valid", {15'd0, instr_valid}, 16'd0);
    $display("long wait without ack: req=%b halted=%b err=%b", imem_req, halted, fetch_err);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 SHALL provide parameter HALT_OPCODE, default 4'hF, value of instr[15:12] that halts fetch.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 15, max wait cycles for imem_ack (used only under REQ-027).
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 pc_next  input  16  next PC from branch/PC-control logic, valid while instr_valid=1.
REQ-008 stall  input  1  hold PC advance (pipeline hazard).
REQ-009 imem_req  output  1  instruction memory read request.
REQ-010 imem_addr  output  16  read address, equals pc_cur.
REQ-011 imem_ack  input  1  one-cycle pulse, imem_rdata valid this cycle.
REQ-012 imem_rdata  input  16  fetched instruction word.
REQ-013 instr  output  16  registered instruction presented to decode.
REQ-014 instr_valid  output  1  instr and pc_cur valid.
REQ-015 instr_ready  input  1  decode accepts instr this cycle.
REQ-016 pc_cur  output  16  PC of current fetch/instruction (feeds PC-control pc_in).
REQ-017 halted  output  1  fetch stopped by halt opcode or error.
REQ-018 fetch_err  output  1  timeout error flag (constant 0 when REQ-027 macro absent).

Function
REQ-019 States SHALL be FETCH, HOLD, HALT, encoded in registers.
REQ-020 FETCH: imem_req=1, imem_addr=pc_cur; on imem_ack, instr<=imem_rdata, instr_valid<=1, next state HOLD; imem_rdata outside ack ignored.
REQ-021 imem_addr and imem_req SHALL stay stable while in FETCH until ack; imem_req=0 in HOLD and HALT.
REQ-022 HOLD: when instr_ready=1 and stall=0 (accept), pc_cur<={pc_next[15:1],1'b0}, instr_valid<=0; next state HALT if instr[15:12]==HALT_OPCODE, else FETCH.
REQ-023 HOLD with stall=1 or instr_ready=0: all outputs and pc_cur held; stall takes priority over instr_ready.
REQ-024 HALT: halted=1, instr_valid=0, imem_req=0, pc_cur frozen at value from REQ-022; only reset exits.
REQ-025 Latency: ack cycle to instr_valid=1 is exactly 1 clock; accept cycle to next imem_req=1 is exactly 1 clock; minimum 2 cycles per instruction.
REQ-026 pc_cur SHALL wrap 16'hFFFE -> any pc_next value without special handling (no arithmetic in this block).

Reset
REQ-028 On rst_n=0, immediately: pc_cur=RESET_PC, instr=16'h0000, instr_valid=0, halted=0, fetch_err=0, timeout counter=0, state=FETCH (imem_req=1 only after rst_n deasserts).
REQ-029 Reset asserted mid-fetch SHALL abandon the request; an imem_ack during reset is ignored.

Configuration
REQ-027 Macro FETCH_TIMEOUT_EN: when defined, a counter increments each FETCH cycle without ack, clears on ack/state exit; on reaching TIMEOUT_CYCLES without ack, fetch_err<=1 (sticky), state<=HALT, halted=1; ack in same cycle as limit wins (normal fetch). When undefined, no counter, fetch_err tied 0, FETCH waits indefinitely.

Verification
REQ-030 Reset release, imem_ack 2 cycles later with rdata=16'h1234 -> imem_addr=16'h0000 during wait, instr=16'h1234, instr_valid=1 the next cycle.
REQ-031 HOLD with instr_ready=1, stall=1 for 3 cycles, then stall=0, pc_next=16'h0042 -> pc_cur held 3 cycles, then 16'h0042, imem_req=1 next cycle.
REQ-032 pc_next=16'h0043 on accept -> pc_cur=16'h0042 (LSB forced 0).
REQ-033 rdata=16'hF000 accepted -> halted=1, imem_req=0 thereafter, pc_cur frozen, further acks ignored.
REQ-034 With FETCH_TIMEOUT_EN, no ack for 15 cycles -> fetch_err=1, halted=1; ack on 15th cycle -> no error, instr captured.
REQ-035 rst_n pulsed low while in HOLD with instr_valid=1 -> instr_valid=0, pc_cur=RESET_PC asynchronously, FETCH resumes after release.
